// File: rtl/uart_tx_ctrl_pkg.sv
// Shared USART definitions: FSM encoding and line constants.
// Also used by the receive controller.
package uart_tx_ctrl_pkg;

  localparam int DATA_W = 8;

  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARMED = 3'd1;
  localparam logic [2:0] ST_START = 3'd2;
  localparam logic [2:0] ST_DATA  = 3'd3;
  localparam logic [2:0] ST_NINTH = 3'd4;
  localparam logic [2:0] ST_STOP  = 3'd5;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    ARMED = ST_ARMED,
    START = ST_START,
    DATA  = ST_DATA,
    NINTH = ST_NINTH,
    STOP  = ST_STOP
  } state_e;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// USART transmit control bundle.
// master = SFR/baud side, slave = transmit sequencer.
interface uart_tx_ctrl_if;
  import uart_tx_ctrl_pkg::*;

  logic              txen;
  logic              tx9;
  logic              tx9d;
  logic              txreg_wr_en;
  logic [DATA_W-1:0] txreg_in;
  logic              baud_tick;
  logic              tx_out;
  logic              txif;
  logic              trmt;

  modport master (
    output txen, tx9, tx9d,
    output txreg_wr_en, txreg_in,
    output baud_tick,
    input  tx_out, txif, trmt
  );

  modport slave (
    input  txen, tx9, tx9d,
    input  txreg_wr_en, txreg_in,
    input  baud_tick,
    output tx_out, txif, trmt
  );

endinterface

// File: rtl/uart_tx_ctrl.sv
// USART async transmit sequencer: TXREG, TSR and framing.
// Start, 8 data LSB first, optional 9th bit, stop.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  uart_tx_ctrl_if.slave  bus
);

  state_e            state_q;
  logic [DATA_W-1:0] txreg_q;
  logic [DATA_W-1:0] tsr_q;
  logic              full_q;
  logic              ninth_q;
  logic [2:0]        bit_cnt_q;
  logic              tx_q;
  logic              trmt_q;
  logic              xfer;

  localparam logic [2:0] LAST_BIT = 3'(DATA_W - 1);

  // TXREG -> TSR move: any idle cycle, or the stop tick
  assign xfer = full_q & bus.txen &
                ((state_q == IDLE) |
                 ((state_q == STOP) & bus.baud_tick));

  // Holding register, frame FSM and registered line outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      txreg_q   <= '0;
      tsr_q     <= '0;
      full_q    <= 1'b0;
      ninth_q   <= 1'b0;
      bit_cnt_q <= '0;
      tx_q      <= IDLE_LEVEL;
      trmt_q    <= 1'b1;
    end else begin
      if (bus.txreg_wr_en) begin
        txreg_q <= bus.txreg_in;
        full_q  <= 1'b1;
      end else if (xfer) begin
        full_q  <= 1'b0;
      end

      if (!bus.txen) begin
        state_q <= IDLE;
        tsr_q   <= '0;
        tx_q    <= IDLE_LEVEL;
        trmt_q  <= 1'b1;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (xfer) begin
              tsr_q   <= txreg_q;
              ninth_q <= bus.tx9d;
              trmt_q  <= 1'b0;
              state_q <= ARMED;
            end
          end
          ARMED: begin
            if (bus.baud_tick) begin
              tx_q    <= 1'b0;
              state_q <= START;
            end
          end
          START: begin
            if (bus.baud_tick) begin
              tx_q      <= tsr_q[0];
              tsr_q     <= {1'b0, tsr_q[DATA_W-1:1]};
              bit_cnt_q <= '0;
              state_q   <= DATA;
            end
          end
          DATA: begin
            if (bus.baud_tick) begin
              if (bit_cnt_q != LAST_BIT) begin
                tx_q      <= tsr_q[0];
                tsr_q     <= {1'b0, tsr_q[DATA_W-1:1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
              end else if (bus.tx9) begin
                tx_q    <= ninth_q;
                state_q <= NINTH;
              end else begin
                tx_q    <= 1'b1;
                state_q <= STOP;
              end
            end
          end
          NINTH: begin
            if (bus.baud_tick) begin
              tx_q    <= 1'b1;
              state_q <= STOP;
            end
          end
          STOP: begin
            if (bus.baud_tick) begin
              if (xfer) begin
                tsr_q   <= txreg_q;
                ninth_q <= bus.tx9d;
                tx_q    <= 1'b0;
                state_q <= START;
              end else begin
                trmt_q  <= 1'b1;
                state_q <= IDLE;
              end
            end
          end
          default: begin
            tx_q    <= IDLE_LEVEL;
            trmt_q  <= 1'b1;
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.tx_out = tx_q;
  assign bus.txif   = ~full_q;
  assign bus.trmt   = trmt_q;

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Transmit sequencer for the PIC16F USART, asynchronous mode. It owns the TXREG holding register and the TSR shift register, and frames each byte as start, 8 data bits LSB first, an optional 9th bit, then stop. Each bit is advanced on the one-cycle baud tick from the baud rate generator (its uart_tx_shift_en output). It produces the TX pin level and the TXIF/TRMT status bits for the SFR/interrupt logic.

Parameters:
DATA_W, 8, data bits per frame; fixed at 8 for PIC compatibility and not overridden in this design.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
txen  input  1  TXSTA.TXEN; transmitter enable
tx9  input  1  TXSTA.TX9; 1 = 9-bit frames
tx9d  input  1  TXSTA.TX9D; 9th data bit
txreg_wr_en  input  1  write strobe for TXREG
txreg_in  input  8  TXREG write data
baud_tick  input  1  one-cycle bit-period pulse from the baud rate generator
tx_out  output  1  serial TX line; idle high
txif  output  1  1 = TXREG empty (level, not a pulse)
trmt  output  1  TXSTA.TRMT; 1 = TSR empty, line idle

Behaviour:
- Reset (rst=1, synchronous): tx_out=1, txif=1, trmt=1, state=IDLE, tsr=0, txreg=0, bit_cnt=0. Reset mid-frame aborts the frame immediately.
- TXREG write: on txreg_wr_en, txreg<=txreg_in and full<=1 (txif=0 next cycle).
  - Writing while full overwrites silently; no error flag.
  - Writes are accepted regardless of txen.
- Transfer TXREG->TSR happens when full=1 and txen=1, in two cases:
  - state=IDLE, on any cycle;
  - state=STOP, on the cycle baud_tick=1 (back-to-back frames).
- On transfer: tsr<=txreg, ninth<=tx9d (sampled at transfer), full<=0.
- If txreg_wr_en coincides with transfer: TSR gets the old txreg value, and the new value lands with full=1.
- States:
  - IDLE: tx_out=1, trmt=1. On transfer -> ARMED.
  - ARMED: TSR loaded, trmt=0. On baud_tick: tx_out<=0 -> START. This aligns the start bit to a tick boundary.
  - START: on baud_tick: tx_out<=tsr[0], shift tsr right, bit_cnt<=0 -> DATA.
  - DATA: on baud_tick with bit_cnt<7: tx_out<=tsr[0], shift, bit_cnt+1.
  - DATA: on baud_tick with bit_cnt==7: if tx9, tx_out<=ninth -> NINTH; else tx_out<=1 -> STOP.
  - NINTH: on baud_tick: tx_out<=1 -> STOP.
  - STOP: on baud_tick: if transfer condition holds, load TSR, tx_out<=0 -> START. Otherwise -> IDLE, trmt<=1.
- Bit timing: each line level is held exactly one baud period (tick to tick). Frame length is 10 periods, or 11 with tx9.
- tx9 is sampled on the DATA bit_cnt==7 tick; changing it mid-frame only affects that decision.
- txen=0: the next cycle forces state=IDLE, tx_out=1, trmt=1, tsr=0. txreg and full are retained and sent once txen returns to 1.
- Outputs are registered; txif = ~full; trmt=1 only in IDLE.
- baud_tick is ignored in IDLE. A tick on the same cycle as an IDLE->ARMED transfer is not consumed.

Decomposition:
- Shared USART package: the state encoding (IDLE, ARMED, START, DATA, NINTH, STOP as 3-bit localparams) and the IDLE_LEVEL=1 constant. The planned uart_rx_ctrl reuses both.
- No sub-module: the TXREG holding register and FSM stay in one file. uart_tx_ctrl is instantiated beside the baud rate generator in the USART top, with baud_tick wired to uart_tx_shift_en.

Test Plan:
- Reset, then idle with ticks every 16 clk -> tx_out=1, txif=1, trmt=1 constant.
- txen=1, tx9=0, write 0xA5 -> txif=0 for 1 cycle, then 1. trmt=0 from the next cycle. On tick boundaries tx_out = 0,1,0,1,0,0,1,0,1,1 (start, LSB-first 0xA5, stop), each held 16 clk. trmt=1 after the stop tick.
- tx9=1, tx9d=1, write 0x00 -> 11 periods: 0, eight 0s, 1 (9th), 1 (stop). Flipping tx9d after transfer has no effect.
- Write 0x55, then 0x0F while the first frame is in DATA -> txif=0 until the stop tick. The second start bit follows the stop with no idle period; trmt stays 0 throughout.
- Drop txen in DATA bit 3 with TXREG holding 0x3C -> tx_out=1, trmt=1 next cycle. Re-raising txen sends 0x3C as a complete frame.
- Simultaneous write 0x77 and IDLE transfer of 0x11 -> 0x11 is sent first, then 0x77; txif=0 until 0x77 transfers.
